// File: rtl/fetch_stage.sv
// fetch_stage: OTTER instruction-fetch stage. Owns the PC, talks to instruction
// memory over a REQ/ACK handshake and loads the IF/ID fetch register.
// Optional build macro FETCH_PERF_CNT_EN adds saturating stall/squash counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        REG_CLOCK,
    input  logic        REG_RESET_N,
    input  logic        PC_WRITE,
    input  logic        IF_ID_WRITE,
    input  logic        IF_ID_FLUSH,
    input  logic [1:0]  PC_SOURCE,
    input  logic [31:0] JALR_TARGET,
    input  logic [31:0] BRANCH_TARGET,
    input  logic [31:0] JAL_TARGET,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_DATA,
    output logic [31:0] FR_MEM,
    output logic [31:0] FR_PC,
    output logic [31:0] FR_PC_4,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] PERF_STALL_CNT,
    output logic [31:0] PERF_SQUASH_CNT,
`endif
    output logic        FR_VALID
);

    typedef enum logic [1:0] {StIdle, StWait, StDrop, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic        redirect, advance, load;
    logic [31:0] target, load_data, load_pc;

    assign redirect = (PC_SOURCE != 2'd0);
    assign advance  = PC_WRITE & IF_ID_WRITE;

    // Redirect target select; the PC+4 arm is never used as a redirect
    always_comb begin
        case (PC_SOURCE)
            2'd1:    target = JALR_TARGET;
            2'd2:    target = BRANCH_TARGET;
            2'd3:    target = JAL_TARGET;
            default: target = pc_q + 32'd4;
        endcase
    end

    // FSM state register
    always_ff @(posedge REG_CLOCK or negedge REG_RESET_N) begin
        if (!REG_RESET_N) state_q <= StIdle;
        else              state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: state_d = StWait;
            StWait: begin
                if (redirect)      state_d = IMEM_ACK ? StWait : StDrop;
                else if (IMEM_ACK) state_d = advance ? StWait : StHold;
            end
            StDrop: if (IMEM_ACK) state_d = StWait;
            StHold: if (redirect || advance) state_d = StWait;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: request is held for the whole WAIT/DROP window at the current PC
    always_comb begin
        IMEM_REQ  = (state_q == StWait) || (state_q == StDrop);
        IMEM_ADDR = pc_q;
    end

    // Datapath next-state: PC, pending redirect, hold buffer and fetch-register load
    always_comb begin
        pc_d        = pc_q;
        pend_d      = pend_q;
        hold_data_d = hold_data_q;
        hold_pc_d   = hold_pc_q;
        load        = 1'b0;
        load_data   = IMEM_DATA;
        load_pc     = pc_q;
        case (state_q)
            StWait: begin
                if (redirect) begin
                    // Coincident ACK data is discarded; otherwise wait out the old request
                    if (IMEM_ACK) pc_d   = target;
                    else          pend_d = target;
                end else if (IMEM_ACK) begin
                    if (advance) begin
                        load = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end else begin
                        hold_data_d = IMEM_DATA;
                        hold_pc_d   = pc_q;
                    end
                end
            end
            StDrop: begin
                if (IMEM_ACK) begin
                    pc_d   = redirect ? target : pend_q;
                    pend_d = 32'd0;
                end else if (redirect) begin
                    pend_d = target;
                end
            end
            StHold: begin
                if (redirect) begin
                    pc_d = target;
                end else if (advance) begin
                    load      = 1'b1;
                    load_data = hold_data_q;
                    load_pc   = hold_pc_q;
                    pc_d      = pc_q + 32'd4;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge REG_CLOCK or negedge REG_RESET_N) begin
        if (!REG_RESET_N) begin
            pc_q        <= RESET_PC;
            pend_q      <= 32'd0;
            hold_data_q <= 32'd0;
            hold_pc_q   <= 32'd0;
        end else begin
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            hold_data_q <= hold_data_d;
            hold_pc_q   <= hold_pc_d;
        end
    end

    // IF/ID fetch register: flush beats write-disable beats load
    always_ff @(posedge REG_CLOCK or negedge REG_RESET_N) begin
        if (!REG_RESET_N) begin
            FR_MEM   <= NOP_INSTR;
            FR_PC    <= 32'd0;
            FR_PC_4  <= 32'd0;
            FR_VALID <= 1'b0;
        end else if (IF_ID_FLUSH) begin
            FR_MEM   <= NOP_INSTR;
            FR_VALID <= 1'b0;
        end else if (IF_ID_WRITE && load) begin
            FR_MEM   <= load_data;
            FR_PC    <= load_pc;
            FR_PC_4  <= load_pc + 32'd4;
            FR_VALID <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic stall_inc, squash_inc;
    assign stall_inc  = (state_q == StHold) || ((state_q == StWait) && !IMEM_ACK);
    assign squash_inc = IMEM_ACK && ((state_q == StDrop) || ((state_q == StWait) && redirect));

    // Saturating performance counters
    always_ff @(posedge REG_CLOCK or negedge REG_RESET_N) begin
        if (!REG_RESET_N) begin
            PERF_STALL_CNT  <= 32'd0;
            PERF_SQUASH_CNT <= 32'd0;
        end else begin
            if (stall_inc && (PERF_STALL_CNT != 32'hFFFF_FFFF))
                PERF_STALL_CNT <= PERF_STALL_CNT + 32'd1;
            if (squash_inc && (PERF_SQUASH_CNT != 32'hFFFF_FFFF))
                PERF_SQUASH_CNT <= PERF_SQUASH_CNT + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a transaction-level model
// checked every cycle plus literal expectations at key points.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        pw    = 1'b1;
    logic        iw    = 1'b1;
    logic        fl    = 1'b0;
    logic [1:0]  src   = 2'd0;
    logic [31:0] jalr_t = 32'd0, br_t = 32'd0, jal_t = 32'd0;
    logic        ack   = 1'b0;
    logic [31:0] data  = 32'd0;
    logic        req;
    logic [31:0] addr, fr_mem, fr_pc, fr_pc4;
    logic        fr_valid;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .REG_CLOCK    (clk),
        .REG_RESET_N  (rst_n),
        .PC_WRITE     (pw),
        .IF_ID_WRITE  (iw),
        .IF_ID_FLUSH  (fl),
        .PC_SOURCE    (src),
        .JALR_TARGET  (jalr_t),
        .BRANCH_TARGET(br_t),
        .JAL_TARGET   (jal_t),
        .IMEM_REQ     (req),
        .IMEM_ADDR    (addr),
        .IMEM_ACK     (ack),
        .IMEM_DATA    (data),
        .FR_MEM       (fr_mem),
        .FR_PC        (fr_pc),
        .FR_PC_4      (fr_pc4),
        .FR_VALID     (fr_valid)
    );

    // Instruction memory contents: 0x100 holds 0x00500093, other words distinct
    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h0050_0093 + ((a - 32'h100) << 8);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks what the stage has promised: whether fetching has begun, whether the
    // in-flight request is doomed (with where to go next), or whether a returned
    // word is parked waiting for the pipeline to accept it.
    logic        m_started = 1'b0, m_squash = 1'b0, m_parked = 1'b0;
    logic [31:0] m_pc = RST_PC, m_sq_tgt = 32'd0, m_park_word = 32'd0;
    logic [31:0] m_fr_mem = NOP, m_fr_pc = 32'd0, m_fr_pc4 = 32'd0;
    logic        m_fr_valid = 1'b0;
    logic        m_take, m_redir, m_go;
    logic [31:0] m_tgt, m_word, m_wpc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started = 1'b0; m_squash = 1'b0; m_parked = 1'b0;
            m_pc = RST_PC; m_sq_tgt = 32'd0;
            m_fr_mem = NOP; m_fr_pc = 32'd0; m_fr_pc4 = 32'd0; m_fr_valid = 1'b0;
        end else begin
            m_redir = (src != 2'd0);
            m_tgt   = (src == 2'd1) ? jalr_t : (src == 2'd2) ? br_t : jal_t;
            m_go    = pw && iw;
            m_take  = 1'b0;
            m_word  = 32'd0;
            m_wpc   = 32'd0;
            if (!m_started) begin
                m_started = 1'b1;
            end else if (m_parked) begin
                if (m_redir) begin
                    m_parked = 1'b0; m_pc = m_tgt;
                end else if (m_go) begin
                    m_parked = 1'b0; m_take = 1'b1; m_word = m_park_word; m_wpc = m_pc;
                    m_pc = m_pc + 32'd4;
                end
            end else if (m_squash) begin
                if (m_redir) m_sq_tgt = m_tgt;
                if (ack) begin
                    m_squash = 1'b0; m_pc = m_sq_tgt;
                end
            end else if (m_redir) begin
                if (ack) m_pc = m_tgt;
                else begin
                    m_squash = 1'b1; m_sq_tgt = m_tgt;
                end
            end else if (ack) begin
                if (m_go) begin
                    m_take = 1'b1; m_word = data; m_wpc = m_pc; m_pc = m_pc + 32'd4;
                end else begin
                    m_parked = 1'b1; m_park_word = data;
                end
            end
            if (fl) begin
                m_fr_mem = NOP; m_fr_valid = 1'b0;
            end else if (iw && m_take) begin
                m_fr_mem = m_word; m_fr_pc = m_wpc; m_fr_pc4 = m_wpc + 32'd4;
                m_fr_valid = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic exp_req;
        exp_req = m_started && !m_parked;
        check("imem_req", {31'd0, req}, {31'd0, exp_req});
        if (exp_req) check("imem_addr", addr, m_pc);
        check("fr_mem", fr_mem, m_fr_mem);
        check("fr_pc", fr_pc, m_fr_pc);
        check("fr_pc_4", fr_pc4, m_fr_pc4);
        check("fr_valid", {31'd0, fr_valid}, {31'd0, m_fr_valid});
    end

    // ---------------- memory responder + stimulus ----------------
    int          waits = 0;
    int          cnt = 0;
    logic        last_req = 1'b0, last_ack = 1'b0;
    logic [31:0] last_addr = 32'd0;

    // Advance one cycle; args are the hazard/redirect inputs for the next edge
    task automatic step(input logic p, input logic i, input logic f, input logic [1:0] s);
        @(posedge clk);
        #1;
        if (req && last_req && (addr == last_addr) && !last_ack) cnt++;
        else cnt = 0;
        ack       = req && (cnt >= waits);
        data      = word(addr);
        last_req  = req;
        last_addr = addr;
        last_ack  = ack;
        pw = p; iw = i; fl = f; src = s;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #3;
        check("rst_req", {31'd0, req}, 32'd0);
        check("rst_fr_mem", fr_mem, 32'h0000_0013);
        check("rst_fr_valid", {31'd0, fr_valid}, 32'd0);
        check("rst_fr_pc", fr_pc, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        check("req_before_first_edge", {31'd0, req}, 32'd0);

        // Zero-wait start-up
        step(1, 1, 0, 0);
        check("first_req", {31'd0, req}, 32'd1);
        check("first_addr", addr, 32'h100);
        step(1, 1, 0, 0);
        check("first_fr_mem", fr_mem, 32'h0050_0093);
        check("first_fr_pc", fr_pc, 32'h100);
        check("first_fr_pc4", fr_pc4, 32'h104);
        check("first_fr_valid", {31'd0, fr_valid}, 32'd1);
        check("second_addr", addr, 32'h104);

        // Stall as ACK arrives at 0x108
        step(0, 0, 0, 0);
        check("stall_addr", addr, 32'h108);
        step(0, 0, 0, 0);
        check("hold_req", {31'd0, req}, 32'd0);
        check("hold_fr_pc", fr_pc, 32'h104);
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        waits = 3;
        step(1, 1, 0, 0);
        check("unstall_fr_pc", fr_pc, 32'h108);
        check("unstall_addr", addr, 32'h10C);

        // Branch on 2nd wait cycle of a 3-wait-state access
        br_t = 32'h200;
        step(1, 1, 0, 2);
        step(1, 1, 0, 0);
        check("drop_addr", addr, 32'h10C);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        check("branch_addr", addr, 32'h200);
        check("branch_old_fr_pc", fr_pc, 32'h108);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        waits = 0;

        // Flush together with IF_ID_WRITE=0
        step(0, 0, 1, 0);
        check("branch_fr_pc", fr_pc, 32'h200);
        check("branch_fr_valid", {31'd0, fr_valid}, 32'd1);
        step(1, 1, 0, 0);
        check("flush_fr_mem", fr_mem, 32'h0000_0013);
        check("flush_fr_valid", {31'd0, fr_valid}, 32'd0);
        check("flush_fr_pc", fr_pc, 32'h200);

        // JAL coincident with ACK, wrapping target
        jal_t = 32'hFFFF_FFFC;
        step(1, 1, 0, 3);
        step(1, 1, 0, 0);
        check("jal_addr", addr, 32'hFFFF_FFFC);
        check("jal_squashed_fr_pc", fr_pc, 32'h204);
        waits = 3;
        step(1, 1, 0, 0);
        check("jal_fr_pc", fr_pc, 32'hFFFF_FFFC);
        check("jal_fr_pc4", fr_pc4, 32'h0);
        check("wrap_addr", addr, 32'h0);

        // Asynchronous reset mid-WAIT, then a late ACK
        step(1, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_req", {31'd0, req}, 32'd0);
        check("async_fr_mem", fr_mem, 32'h0000_0013);
        check("async_fr_valid", {31'd0, fr_valid}, 32'd0);
        check("async_fr_pc", fr_pc, 32'd0);
        @(posedge clk);
        #2;
        ack   = 1'b1;
        data  = 32'hDEAD_BEEF;
        rst_n = 1'b1;
        waits = 0;
        step(1, 1, 0, 0);
        check("late_ack_fr_valid", {31'd0, fr_valid}, 32'd0);
        check("late_ack_fr_mem", fr_mem, 32'h0000_0013);
        check("post_reset_addr", addr, 32'h100);
        step(1, 1, 0, 0);
        check("post_reset_fr_pc", fr_pc, 32'h100);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);

        // JALR redirect while parked in HOLD
        step(0, 0, 0, 0);
        jalr_t = 32'h300;
        step(0, 0, 0, 1);
        waits = 2;
        step(1, 1, 0, 0);
        check("jalr_hold_addr", addr, 32'h300);

        // Two redirects during one squashed request: latest wins
        br_t  = 32'h400;
        jal_t = 32'h500;
        step(1, 1, 0, 2);
        step(1, 1, 0, 3);
        waits = 0;
        step(1, 1, 0, 0);
        check("latest_wins_addr", addr, 32'h500);
        step(1, 1, 0, 0);
        check("latest_wins_fr_pc", fr_pc, 32'h500);
        step(1, 1, 0, 0);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
